// File: rtl/mm_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
// Shared types for the matrix-multiply engine: the controller state encoding
// and the memory index codes placed on the 'index' port.
// -----------------------------------------------------------------------------
package mm_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DIM0,
        DIM1,
        DIM2,
        RDA,
        RDB,
        WR,
        DONE
    } state_t;

    localparam logic [1:0] IDX_A    = 2'd0;
    localparam logic [1:0] IDX_B    = 2'd1;
    localparam logic [1:0] IDX_C    = 2'd2;
    localparam logic [1:0] IDX_DESC = 2'd3;

endpackage

// File: rtl/mm_mac.sv
// -----------------------------------------------------------------------------
// mm_mac
// Multiply-accumulate datapath. Extends both operands to ACC_W (sign or zero
// extension), multiplies modulo 2^ACC_W and accumulates with wrap. The
// accumulator is reduced to OUT_W either by truncation or, when the macro
// MM_SAT_EN is defined, by clamping to the signed/unsigned OUT_W range.
//
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   signed_mode  1 = two's-complement operands and saturation range
//   clear        zero the accumulator (wins over acc_en)
//   acc_en       acc <= acc + ext(a) * ext(b)
//   a, b         DATA_W operands
//   out_data     OUT_W reduced accumulator value
// -----------------------------------------------------------------------------
module mm_mac #(
    parameter int DATA_W = 20,
    parameter int ACC_W  = 48,
    parameter int OUT_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signed_mode,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [OUT_W-1:0]  out_data
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;

    // Extension to the full accumulator width makes an ACC_W-bit product
    // correct modulo 2^ACC_W for both signed and unsigned operands.
    assign a_ext = {{(ACC_W-DATA_W){signed_mode & a[DATA_W-1]}}, a};
    assign b_ext = {{(ACC_W-DATA_W){signed_mode & b[DATA_W-1]}}, b};
    assign prod  = a_ext * b_ext;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= acc_q + prod;
        end
    end

`ifdef MM_SAT_EN
    generate
        if (OUT_W < ACC_W) begin : g_sat
            logic [ACC_W-OUT_W:0]   sign_bits;
            logic [ACC_W-OUT_W-1:0] high_bits;

            assign sign_bits = acc_q[ACC_W-1:OUT_W-1];
            assign high_bits = acc_q[ACC_W-1:OUT_W];

            // NOTE: out_data gets a default before any branch so no path through
            // this block leaves it unassigned (which would infer a latch).
            always_comb begin
                out_data = acc_q[OUT_W-1:0];
                if (signed_mode) begin
                    // Fits only if all bits above the OUT_W sign bit match it.
                    if (!((&sign_bits) || !(|sign_bits))) begin
                        out_data = acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                  : {1'b0, {(OUT_W-1){1'b1}}};
                    end
                end else if (|high_bits) begin
                    out_data = '1;
                end
            end
        end else begin : g_pass
            logic unused_mode;
            assign unused_mode = signed_mode;
            assign out_data    = acc_q[OUT_W-1:0];
        end
    endgenerate
`else
    generate
        if (OUT_W < ACC_W) begin : g_trunc_hi
            logic unused_hi;
            assign unused_hi = ^acc_q[ACC_W-1:OUT_W];
        end
    endgenerate
    logic unused_mode;
    assign unused_mode = signed_mode;
    assign out_data    = acc_q[OUT_W-1:0];
`endif

endmodule

// File: rtl/mm_engine.sv
// -----------------------------------------------------------------------------
// mm_engine
// Matrix-multiply engine: C[M][N] = A[M][K] x B[K][N] over a single-port
// memory interface. Reads M, K, N from the descriptor, then for each C element
// alternates A/B reads for K steps and writes the result row-major.
// Optional output saturation is selected by the macro MM_SAT_EN (see mm_mac).
//
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   start        begin a job (accepted only in IDLE or DONE)
//   signed_mode  operand signedness, latched with start
//   read_data    memory read data, valid in the cycle read=1
//   i, j, index  access address: row, column, matrix (A/B/C/descriptor)
//   read, write  memory strobes
//   write_data   C element, valid while write=1
//   busy         job in progress
//   finish       job complete, held until the next start
//   err          a zero dimension aborted the job
// -----------------------------------------------------------------------------
module mm_engine
    import mm_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 20,
    parameter int ACC_W  = 48,
    parameter int OUT_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] i,
    output logic [ADDR_W-1:0] j,
    output logic [1:0]        index,
    output logic              read,
    output logic              write,
    output logic [OUT_W-1:0]  write_data,
    output logic              busy,
    output logic              finish,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] m_q, k_q, n_q;
    logic [ADDR_W-1:0] r_q, kc_q, c_q;
    logic [DATA_W-1:0] a_q;
    logic              mode_q;
    logic              err_q;

    logic [ADDR_W-1:0] dim_now;
    logic              accept, zero_dim, k_last, c_last, r_last;
    logic              acc_clr, acc_en;
    logic [OUT_W-1:0]  mac_out;

    // Dimension words wider than ADDR_W are truncated.
    assign dim_now  = ADDR_W'(read_data);
    assign zero_dim = (m_q == '0) || (k_q == '0) || (dim_now == '0);
    assign k_last   = (kc_q == k_q - ONE);
    assign c_last   = (c_q == n_q - ONE);
    assign r_last   = (r_q == m_q - ONE);
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        i       = '0;
        j       = '0;
        index   = IDX_A;
        read    = 1'b0;
        write   = 1'b0;
        busy    = 1'b0;
        finish  = 1'b0;
        acc_en  = 1'b0;
        acc_clr = accept;
        unique case (state_q)
            IDLE: if (start) state_d = DIM0;
            DIM0, DIM1, DIM2: begin
                busy  = 1'b1;
                read  = 1'b1;
                index = IDX_DESC;
                if (state_q == DIM0) begin
                    state_d = DIM1;
                end else if (state_q == DIM1) begin
                    i       = ONE;
                    state_d = DIM2;
                end else begin
                    i       = ADDR_W'(2);
                    state_d = zero_dim ? DONE : RDA;
                end
            end
            RDA: begin
                busy    = 1'b1;
                read    = 1'b1;
                index   = IDX_A;
                i       = r_q;
                j       = kc_q;
                state_d = RDB;
            end
            RDB: begin
                busy    = 1'b1;
                read    = 1'b1;
                index   = IDX_B;
                i       = kc_q;
                j       = c_q;
                acc_en  = 1'b1;
                state_d = k_last ? WR : RDA;
            end
            WR: begin
                busy    = 1'b1;
                write   = 1'b1;
                index   = IDX_C;
                i       = r_q;
                j       = c_q;
                acc_clr = 1'b1;
                state_d = (r_last && c_last) ? DONE : RDA;
            end
            DONE: begin
                finish = 1'b1;
                if (start) state_d = DIM0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q    <= '0;
            k_q    <= '0;
            n_q    <= '0;
            r_q    <= '0;
            kc_q   <= '0;
            c_q    <= '0;
            a_q    <= '0;
            mode_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                mode_q <= signed_mode;
                err_q  <= 1'b0;
                r_q    <= '0;
                kc_q   <= '0;
                c_q    <= '0;
            end
            case (state_q)
                DIM0: m_q <= dim_now;
                DIM1: k_q <= dim_now;
                DIM2: begin
                    n_q <= dim_now;
                    if (zero_dim) err_q <= 1'b1;
                end
                RDA:  a_q <= read_data;
                RDB:  if (!k_last) kc_q <= kc_q + ONE;
                WR: begin
                    kc_q <= '0;
                    if (c_last) begin
                        c_q <= '0;
                        r_q <= r_q + ONE;
                    end else begin
                        c_q <= c_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    mm_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .clk         (clk),
        .reset       (reset),
        .signed_mode (mode_q),
        .clear       (acc_clr),
        .acc_en      (acc_en),
        .a           (a_q),
        .b           (read_data),
        .out_data    (mac_out)
    );

    assign write_data = write ? mac_out : '0;
    assign err        = err_q;

endmodule

// File: tb/tb_mm_engine.sv
module tb_mm_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start16, signed_mode;
    logic [19:0] rd, rd16;
    logic [19:0] i, j, i16, j16;
    logic [1:0]  index, index16;
    logic        read, write, busy, finish, err;
    logic        read16, write16, busy16, finish16, err16;
    logic [39:0] write_data;
    logic [15:0] write_data16;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    typedef struct {
        logic [19:0] i;
        logic [19:0] j;
        logic [39:0] d;
    } exp_t;

    exp_t q[$];
    exp_t q16[$];

    logic [19:0] desc[4];
    logic [19:0] a_mem[4][4];
    logic [19:0] b_mem[4][4];

    always #5 clk = ~clk;

    mm_engine dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .read_data(rd), .i(i), .j(j), .index(index), .read(read), .write(write),
        .write_data(write_data), .busy(busy), .finish(finish), .err(err)
    );

    mm_engine #(.OUT_W(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .signed_mode(signed_mode),
        .read_data(rd16), .i(i16), .j(j16), .index(index16), .read(read16),
        .write(write16), .write_data(write_data16), .busy(busy16),
        .finish(finish16), .err(err16)
    );

    always_comb begin
        rd = '0;
        if (read) begin
            case (index)
                2'd0:    rd = a_mem[i[1:0]][j[1:0]];
                2'd1:    rd = b_mem[i[1:0]][j[1:0]];
                2'd3:    rd = desc[i[1:0]];
                default: rd = '0;
            endcase
        end
    end

    always_comb begin
        rd16 = '0;
        if (read16) begin
            case (index16)
                2'd0:    rd16 = a_mem[i16[1:0]][j16[1:0]];
                2'd1:    rd16 = b_mem[i16[1:0]][j16[1:0]];
                2'd3:    rd16 = desc[i16[1:0]];
                default: rd16 = '0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: every write strobe pops one expected element.
    always @(negedge clk) begin
        if (write) begin
            wr_count++;
            check("rw_exclusive", {63'd0, read}, 64'd0);
            check("write_expected", {63'd0, q.size() > 0}, 64'd1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("write_i", i, e.i);
                check("write_j", j, e.j);
                check("write_data", write_data, e.d);
            end
        end
        if (write16) begin
            check("write16_expected", {63'd0, q16.size() > 0}, 64'd1);
            if (q16.size() > 0) begin
                exp_t e;
                e = q16.pop_front();
                check("write16_data", write_data16, e.d);
            end
        end
    end

    function automatic longint ext(input logic [19:0] v, input logic s);
        return s ? longint'($signed(v)) : longint'({44'd0, v});
    endfunction

    task automatic load_mat(input int m, input int k, input int n, input logic s, input bit push);
        desc[0] = 20'(m);
        desc[1] = 20'(k);
        desc[2] = 20'(n);
        desc[3] = '0;
        if (push) begin
            for (int r = 0; r < m; r++) begin
                for (int c = 0; c < n; c++) begin
                    longint sum;
                    exp_t   e;
                    sum = 0;
                    for (int kk = 0; kk < k; kk++)
                        sum += ext(a_mem[r][kk], s) * ext(b_mem[kk][c], s);
                    e.i = 20'(r);
                    e.j = 20'(c);
                    e.d = 40'(sum);
                    q.push_back(e);
                end
            end
        end
    endtask

    // Pulse start for one edge, then count edges until finish (bounded).
    task automatic run_job(input string tag, input logic s, input bit sel16,
                           input int exp_edges, input int poke_at);
        int got;
        got = -1;
        @(negedge clk);
        signed_mode = s;
        if (sel16) start16 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start16 = 1'b0;
        check({tag, "_busy"}, {63'd0, (sel16 ? busy16 : busy)}, 64'd1);
        check({tag, "_err_cleared"}, {63'd0, (sel16 ? err16 : err)}, 64'd0);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if ((sel16 ? finish16 : finish) === 1'b1) begin
                got = n;
                break;
            end
            if (n == poke_at) start = 1'b1;
        end
        check({tag, "_latency"}, 64'(got), 64'(exp_edges));
    endtask

    task automatic set_test1();
        a_mem[0][0] = 20'd1; a_mem[0][1] = 20'd2;
        a_mem[1][0] = 20'd3; a_mem[1][1] = 20'd4;
        b_mem[0][0] = 20'd5; b_mem[0][1] = 20'd6;
        b_mem[1][0] = 20'd7; b_mem[1][1] = 20'd8;
    endtask

    initial begin
        exp_t e;
        int   wr_before;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_mem[r][c] = '0;
                b_mem[r][c] = '0;
            end
        for (int n = 0; n < 4; n++) desc[n] = '0;
        start = 1'b0;
        start16 = 1'b0;
        signed_mode = 1'b0;
        reset = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {i, j, index, read, write, busy, finish, err},
              64'd0);
        check("rst_write_data", write_data, 64'd0);
        reset = 1'b0;

        // Test 1: signed 2x2x2
        set_test1();
        load_mat(2, 2, 2, 1'b1, 1'b1);
        check("t1_model_00", q[0].d, 64'd19);
        run_job("t1", 1'b1, 1'b0, 23, 0);
        check("t1_err", {63'd0, err}, 64'd0);
        check("t1_all_written", 64'(q.size()), 64'd0);
        @(negedge clk);
        check("t1_finish_held", {61'd0, finish, busy, read}, 64'b100);

        // Test 2: signed -1 * 3
        a_mem[0][0] = 20'hFFFFF;
        b_mem[0][0] = 20'd3;
        load_mat(1, 1, 1, 1'b1, 1'b0);
        e.i = '0; e.j = '0; e.d = 40'hFFFFFFFFFD;
        q.push_back(e);
        run_job("t2", 1'b1, 1'b0, 6, 0);
        check("t2_all_written", 64'(q.size()), 64'd0);

        // Test 3: unsigned 0xFFFFF * 2
        b_mem[0][0] = 20'd2;
        load_mat(1, 1, 1, 1'b0, 1'b0);
        e.d = 40'h00001FFFFE;
        q.push_back(e);
        run_job("t3", 1'b0, 1'b0, 6, 0);
        check("t3_all_written", 64'(q.size()), 64'd0);

        // Test 4: K=0 -> error, no writes
        wr_before = wr_count;
        load_mat(2, 0, 2, 1'b1, 1'b0);
        run_job("t4", 1'b1, 1'b0, 3, 0);
        check("t4_err", {63'd0, err}, 64'd1);
        check("t4_no_writes", 64'(wr_count), 64'(wr_before));
        @(negedge clk);
        check("t4_err_held", {62'd0, finish, err}, 64'b11);

        // Test 5: OUT_W=16, 1000*1000
        a_mem[0][0] = 20'd1000;
        b_mem[0][0] = 20'd1000;
        load_mat(1, 1, 1, 1'b1, 1'b0);
        e.i = '0; e.j = '0;
`ifdef MM_SAT_EN
        e.d = 40'h7FFF;
`else
        e.d = 40'h4240;
`endif
        q16.push_back(e);
        run_job("t5", 1'b1, 1'b1, 6, 0);
        check("t5_all_written", 64'(q16.size()), 64'd0);

        // Test 6: reset during RDB of element (0,1); only (0,0) is written
        set_test1();
        load_mat(2, 2, 2, 1'b1, 1'b0);
        e.i = '0; e.j = '0; e.d = 40'd19;
        q.push_back(e);
        @(negedge clk);
        signed_mode = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("t6_in_rdb", {40'd0, i, index, read}, {40'd0, 20'd0, 2'd1, 1'b1});
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_outputs", {i, j, index, read, write, busy, finish, err},
              64'd0);
        check("t6_rst_write_data", write_data, 64'd0);
        check("t6_only_first_written", 64'(q.size()), 64'd0);
        reset = 1'b0;

        // Restart after abort, with a start pulse mid-job that must be ignored
        load_mat(2, 2, 2, 1'b1, 1'b1);
        run_job("t6_restart", 1'b1, 1'b0, 23, 5);
        check("t6_restart_all_written", 64'(q.size()), 64'd0);
        check("t6_restart_err", {63'd0, err}, 64'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
